cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL expose parameter ROB_W, default 5, ROB index width.
REQ-002 SHALL expose parameter DATA_W, default 32, result value width.
REQ-003 SHALL have ports (clock and reset first):
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  when low, the block pauses and holds all state.
- clear_in  input  1  pipeline flush, driven on ROB mispredict.
- alu_valid  input  1  ALU result offered.
- alu_rob_id  input  ROB_W  ROB entry of the ALU result.
- alu_value  input  DATA_W  ALU result value.
- alu_ready  output  1  ALU result accepted this cycle.
- lsb_valid  input  1  LSB result offered.
- lsb_rob_id  input  ROB_W  ROB entry of the LSB result.
- lsb_value  input  DATA_W  LSB result value.
- lsb_ready  output  1  LSB result accepted this cycle.
- cdb_valid  output  1  broadcast valid, registered.
- cdb_rob_id  output  ROB_W  broadcast ROB entry, registered.
- cdb_value  output  DATA_W  broadcast value, registered.
- cdb_src  output  1  source of the broadcast: 0 = ALU, 1 = LSB.

Function
REQ-004 SHALL hold a 2-entry FIFO per requester (ALU, LSB); each entry stores {rob_id, value}.
REQ-005 SHALL assert x_ready combinationally when all of these hold: rdy_in=1, clear_in=0, and x FIFO count<2 or x is granted this cycle.
REQ-006 SHALL push into a FIFO on the rising edge when x_valid && x_ready; FIFO order is strictly preserved.
REQ-007 SHALL treat a push and a pop in the same cycle on a full FIFO as legal; the count stays at 2.
REQ-008 SHALL perform at most one grant per cycle, taken from the FIFO heads only; an input is never bypassed to the CDB.
REQ-009 SHALL make a grant, when rdy_in=1 and clear_in=0, pop the granted head and register it onto cdb_* at the same edge; cdb_valid=1 for exactly that following cycle.
REQ-010 SHALL drive cdb_valid=0 on the edge after any cycle with no grant; cdb_rob_id, cdb_value and cdb_src hold their last values.
REQ-011 SHALL have a minimum latency of 2 cycles: a push at edge N into an empty FIFO appears on cdb_valid in the cycle after edge N+1.
REQ-012 SHALL, with only one FIFO non-empty, grant that FIFO.
REQ-013 SHALL, with both FIFOs non-empty, choose the winner per the Configuration section.
REQ-014 SHALL sustain 1 broadcast per cycle while any FIFO is non-empty.
REQ-015 SHALL, when clear_in=1 (and rdy_in=1), empty both FIFOs, drive cdb_valid=0 next cycle, perform no push and no grant, and leave last_grant unchanged.
REQ-016 SHALL, when rdy_in=0, hold all registers (including cdb_valid) and force alu_ready=lsb_ready=0; clear_in is ignored while rdy_in=0.
REQ-017 SHALL keep FIFO pointers as 1-bit wrap-around indices and the count as 2 bits; overflow and underflow are impossible by construction.

Reset
REQ-018 SHALL, with rst_in=1 at a rising edge (rst_in takes priority over rdy_in and clear_in), set:
- both FIFO counts and pointers to 0;
- cdb_valid=0, cdb_rob_id=0, cdb_value=0, cdb_src=0;
- last_grant=1 (LSB).
REQ-019 SHALL make alu_ready and lsb_ready follow REQ-005 during and after reset, so both are 1 in the first cycle after reset if rdy_in=1.

Configuration
REQ-020 SHALL, when macro CDB_ROUND_ROBIN_EN is defined, resolve ties (both FIFOs non-empty) to the requester that is not last_grant, and update last_grant on every grant.
REQ-021 SHALL, when CDB_ROUND_ROBIN_EN is undefined, resolve ties by fixed priority, LSB over ALU; last_grant still updates but does not affect arbitration.

Verification
REQ-022 Single push: alu push {rob_id=3, value=0x11} into empty block -> cdb_valid=1, rob_id=3, value=0x11, src=0 exactly 2 cycles later, one cycle wide.
REQ-023 Tie after reset: ALU {1,0xA} and LSB {2,0xB} pushed in the same cycle -> with the macro, broadcasts are ALU rob 1 then LSB rob 2 on consecutive cycles; without it, LSB rob 2 first, then ALU rob 1.
REQ-024 Full/backpressure: push ALU {4,5,6} on consecutive cycles with the LSB FIFO kept non-empty and winning -> alu_ready=0 on the third offer while the ALU FIFO is full; rob 6 is accepted later; ALU order on the CDB is 4, 5, 6.
REQ-025 Flush: both FIFOs hold 2 entries, assert clear_in for 1 cycle -> cdb_valid=0 the next cycle and no stale rob_id is ever broadcast; a new ALU push {7,0x77} after the clear broadcasts normally.
REQ-026 Pause: hold rdy_in=0 for 3 cycles with cdb_valid=1 and entries pending -> cdb outputs frozen, alu_ready=lsb_ready=0; resuming produces the same broadcast sequence as an unpaused run.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter for two result producers (ALU, LSB).
// Each producer feeds its own 2-entry FIFO. At most one FIFO head is granted
// per cycle, and the winner is registered onto the cdb_* outputs.
// Configuration macro CDB_ROUND_ROBIN_EN: when defined, a tie goes to the
// requester that was not granted last. When undefined (the default), the LSB
// wins a tie.
// rdy_in low freezes every register. clear_in (with rdy_in high) flushes both
// FIFOs.

module cdb_fifo2 #(
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [ROB_W-1:0]  push_rob_id,
  input  logic [DATA_W-1:0] push_value,
  output logic [ROB_W-1:0]  head_rob_id,
  output logic [DATA_W-1:0] head_value,
  output logic [1:0]        count
);

  logic [ROB_W-1:0]  rob_mem   [2];
  logic [DATA_W-1:0] value_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  assign head_rob_id = rob_mem[rd_ptr];
  assign head_value  = value_mem[rd_ptr];

  // Pointer and occupancy tracking. The 1-bit pointers wrap naturally.
  // A simultaneous push and pop leaves the count unchanged, even when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (en) begin
      if (flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage. The caller only asserts push when accepting is legal.
  always_ff @(posedge clk) begin
    if (!rst && en && !flush && push) begin
      rob_mem[wr_ptr]   <= push_rob_id;
      value_mem[wr_ptr] <= push_value;
    end
  end

endmodule

module cdb_arbiter #(
  parameter int ROB_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              alu_valid,
  input  logic [ROB_W-1:0]  alu_rob_id,
  input  logic [DATA_W-1:0] alu_value,
  output logic              alu_ready,
  input  logic              lsb_valid,
  input  logic [ROB_W-1:0]  lsb_rob_id,
  input  logic [DATA_W-1:0] lsb_value,
  output logic              lsb_ready,
  output logic              cdb_valid,
  output logic [ROB_W-1:0]  cdb_rob_id,
  output logic [DATA_W-1:0] cdb_value,
  output logic              cdb_src
);

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_LSB = 1'b1;

  logic              active;
  logic [1:0]        alu_count;
  logic [1:0]        lsb_count;
  logic [ROB_W-1:0]  alu_head_rob_id;
  logic [DATA_W-1:0] alu_head_value;
  logic [ROB_W-1:0]  lsb_head_rob_id;
  logic [DATA_W-1:0] lsb_head_value;
  logic              alu_nonempty;
  logic              lsb_nonempty;
  logic              tie_to_alu;
  logic              grant_alu;
  logic              grant_lsb;
  logic              alu_push;
  logic              lsb_push;
  logic              last_grant;

  // Pushes and grants happen only when not paused and not flushing.
  assign active       = rdy_in && !clear_in;
  assign alu_nonempty = (alu_count != 2'd0);
  assign lsb_nonempty = (lsb_count != 2'd0);

  // Tie-break rule, then a single grant chosen from the FIFO heads.
  always_comb begin
    tie_to_alu = 1'b0;
`ifdef CDB_ROUND_ROBIN_EN
    tie_to_alu = (last_grant == SRC_LSB);
`else
    tie_to_alu = 1'b0;
`endif
    grant_alu = active && alu_nonempty && (!lsb_nonempty || tie_to_alu);
    grant_lsb = active && lsb_nonempty && !grant_alu;
  end

  // A full FIFO still accepts a push when its head is popped in the same cycle.
  always_comb begin
    alu_ready = active && ((alu_count != 2'd2) || grant_alu);
    lsb_ready = active && ((lsb_count != 2'd2) || grant_lsb);
  end

  assign alu_push = alu_valid && alu_ready;
  assign lsb_push = lsb_valid && lsb_ready;

  cdb_fifo2 #(.ROB_W(ROB_W), .DATA_W(DATA_W)) u_alu_fifo (
    .clk         (clk_in),
    .rst         (rst_in),
    .en          (rdy_in),
    .flush       (clear_in),
    .push        (alu_push),
    .pop         (grant_alu),
    .push_rob_id (alu_rob_id),
    .push_value  (alu_value),
    .head_rob_id (alu_head_rob_id),
    .head_value  (alu_head_value),
    .count       (alu_count)
  );

  cdb_fifo2 #(.ROB_W(ROB_W), .DATA_W(DATA_W)) u_lsb_fifo (
    .clk         (clk_in),
    .rst         (rst_in),
    .en          (rdy_in),
    .flush       (clear_in),
    .push        (lsb_push),
    .pop         (grant_lsb),
    .push_rob_id (lsb_rob_id),
    .push_value  (lsb_value),
    .head_rob_id (lsb_head_rob_id),
    .head_value  (lsb_head_value),
    .count       (lsb_count)
  );

  // Remember who won last. This is kept in both builds; only round robin reads it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_grant <= SRC_LSB;
    end else if (rdy_in) begin
      last_grant <= (last_grant & ~grant_alu) | grant_lsb;
    end
  end

  // Register the granted head onto the bus. Payload holds when nothing is granted.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      cdb_src    <= SRC_ALU;
    end else if (rdy_in) begin
      if (grant_alu) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= alu_head_rob_id;
        cdb_value  <= alu_head_value;
        cdb_src    <= SRC_ALU;
      end else if (grant_lsb) begin
        cdb_valid  <= 1'b1;
        cdb_rob_id <= lsb_head_rob_id;
        cdb_value  <= lsb_head_value;
        cdb_src    <= SRC_LSB;
      end else begin
        cdb_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter. A queue-based model predicts the arbiter every cycle,
// and directed scenarios pin the model with hand-computed values.
`timescale 1ns/1ps
module tb_cdb_arbiter;
  localparam int ROB_W  = 5;
  localparam int DATA_W = 32;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, clear_in;
  logic              alu_valid, lsb_valid;
  logic [ROB_W-1:0]  alu_rob_id, lsb_rob_id;
  logic [DATA_W-1:0] alu_value, lsb_value;
  logic              alu_ready, lsb_ready;
  logic              cdb_valid, cdb_src;
  logic [ROB_W-1:0]  cdb_rob_id;
  logic [DATA_W-1:0] cdb_value;

  cdb_arbiter #(.ROB_W(ROB_W), .DATA_W(DATA_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_value(alu_value), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value), .lsb_ready(lsb_ready),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value), .cdb_src(cdb_src)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [ROB_W-1:0]  rob;
    logic [DATA_W-1:0] val;
  } ent_t;

  ent_t              mq_alu[$];
  ent_t              mq_lsb[$];
  bit                known = 1'b0;
  logic              m_last, m_valid, m_src;
  logic [ROB_W-1:0]  m_rob;
  logic [DATA_W-1:0] m_val;
  logic [ROB_W-1:0]  seen_alu[$];
  int                n_bcast = 0;
  int                n_checks = 0;
  int                n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: checks the DUT against its prediction, then advances by the coming edge.
  always @(negedge clk_in) begin : model_p
    bit   ga, gl, ra, rl, tie_alu;
    ent_t e;
    if (known) begin
      chk("m_cdb_valid", cdb_valid, m_valid);
      chk("m_cdb_rob_id", cdb_rob_id, m_rob);
      chk("m_cdb_value", cdb_value, m_val);
      chk("m_cdb_src", cdb_src, m_src);
      if (cdb_valid === 1'b1) begin
        n_bcast++;
        if (cdb_src === 1'b0) seen_alu.push_back(cdb_rob_id);
      end
    end
`ifdef CDB_ROUND_ROBIN_EN
    tie_alu = (m_last == 1'b1);
`else
    tie_alu = 1'b0;
`endif
    ga = (mq_alu.size() > 0) && ((mq_lsb.size() == 0) || tie_alu);
    gl = (mq_lsb.size() > 0) && !ga;
    ra = rdy_in && !clear_in && ((mq_alu.size() < 2) || ga);
    rl = rdy_in && !clear_in && ((mq_lsb.size() < 2) || gl);
    if (known) begin
      chk("m_alu_ready", alu_ready, ra);
      chk("m_lsb_ready", lsb_ready, rl);
    end
    if (rst_in) begin
      mq_alu.delete(); mq_lsb.delete();
      m_last = 1'b1; m_valid = 1'b0; m_rob = '0; m_val = '0; m_src = 1'b0;
      known = 1'b1;
    end else if (rdy_in) begin
      if (clear_in) begin
        mq_alu.delete(); mq_lsb.delete();
        m_valid = 1'b0;
      end else begin
        if (ga) begin
          e = mq_alu.pop_front();
          m_valid = 1'b1; m_rob = e.rob; m_val = e.val; m_src = 1'b0; m_last = 1'b0;
        end else if (gl) begin
          e = mq_lsb.pop_front();
          m_valid = 1'b1; m_rob = e.rob; m_val = e.val; m_src = 1'b1; m_last = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
        if (alu_valid && ra) mq_alu.push_back('{rob: alu_rob_id, val: alu_value});
        if (lsb_valid && rl) mq_lsb.push_back('{rob: lsb_rob_id, val: lsb_value});
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; lsb_valid = 1'b0; clear_in = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic offer_alu(input int rob, input int val);
    alu_valid = 1'b1; alu_rob_id = ROB_W'(rob); alu_value = DATA_W'(val);
  endtask

  task automatic offer_lsb(input int rob, input int val);
    lsb_valid = 1'b1; lsb_rob_id = ROB_W'(rob); lsb_value = DATA_W'(val);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic       acc;
    int         snap;
    logic [4:0] first_rob, second_rob;
    logic       first_src, second_src;
    alu_rob_id = '0; alu_value = '0; lsb_rob_id = '0; lsb_value = '0;
    rst_in = 1'b1;
    idle_inputs();

    // Single ALU push: visible two edges after it is accepted, for one cycle only.
    do_reset();
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_rob_id", cdb_rob_id, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_lsb_ready", lsb_ready, 1);
    offer_alu(3, 'h11);
    tick();
    alu_valid = 1'b0;
    chk("single_not_yet", cdb_valid, 0);
    tick();
    chk("single_valid", cdb_valid, 1);
    chk("single_rob", cdb_rob_id, 3);
    chk("single_value", cdb_value, 'h11);
    chk("single_src", cdb_src, 0);
    tick();
    chk("single_one_wide", cdb_valid, 0);
    chk("single_hold_rob", cdb_rob_id, 3);

    // A tie right after reset. last_grant resets to LSB.
    do_reset();
    offer_alu(1, 'hA);
    offer_lsb(2, 'hB);
    tick();
    idle_inputs();
    tick();
`ifdef CDB_ROUND_ROBIN_EN
    first_rob = 5'd1; first_src = 1'b0; second_rob = 5'd2; second_src = 1'b1;
`else
    first_rob = 5'd2; first_src = 1'b1; second_rob = 5'd1; second_src = 1'b0;
`endif
    chk("tie_first_valid", cdb_valid, 1);
    chk("tie_first_rob", cdb_rob_id, first_rob);
    chk("tie_first_src", cdb_src, first_src);
    tick();
    chk("tie_second_valid", cdb_valid, 1);
    chk("tie_second_rob", cdb_rob_id, second_rob);
    chk("tie_second_src", cdb_src, second_src);
    tick();
    chk("tie_done", cdb_valid, 0);

    // Backpressure on the ALU while the LSB keeps competing.
    do_reset();
    seen_alu.delete();
    offer_alu(4, 'h40); offer_lsb(20, 'h200);
    tick();
    offer_alu(5, 'h50); offer_lsb(21, 'h210);
    tick();
    offer_alu(6, 'h60); offer_lsb(22, 'h220);
    acc = alu_ready;
`ifdef CDB_ROUND_ROBIN_EN
    chk("full_third_offer_ready", acc, 1);
`else
    chk("full_third_offer_ready", acc, 0);
`endif
    tick();
    lsb_valid = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = alu_ready;
      tick();
    end
    alu_valid = 1'b0;
    chk("alu6_accepted", acc, 1);
    repeat (6) tick();
    chk("alu_order_count", seen_alu.size(), 3);
    chk("alu_order_0", seen_alu[0], 4);
    chk("alu_order_1", seen_alu[1], 5);
    chk("alu_order_2", seen_alu[2], 6);

    // Flush with both FIFOs loaded. Nothing stale may reach the bus afterwards.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      offer_alu(10 + k, 'h100 + k);
      offer_lsb(20 + k, 'h200 + k);
      tick();
    end
    clear_in = 1'b1;
    offer_alu(13, 'h103);
    offer_lsb(23, 'h203);
    #1;
    chk("clear_alu_ready", alu_ready, 0);
    chk("clear_lsb_ready", lsb_ready, 0);
    tick();
    idle_inputs();
    chk("clear_valid_next", cdb_valid, 0);
    snap = n_bcast;
    repeat (4) tick();
    chk("clear_no_stale", n_bcast - snap, 0);
    offer_alu(7, 'h77);
    tick();
    alu_valid = 1'b0;
    tick();
    chk("post_clear_valid", cdb_valid, 1);
    chk("post_clear_rob", cdb_rob_id, 7);
    chk("post_clear_value", cdb_value, 'h77);
    tick();

    // Pause with a broadcast on the bus and one entry still pending.
    do_reset();
    offer_alu(8, 'h80);
    offer_lsb(9, 'h90);
    tick();
    idle_inputs();
    tick();
`ifdef CDB_ROUND_ROBIN_EN
    first_rob = 5'd8; first_src = 1'b0; second_rob = 5'd9; second_src = 1'b1;
`else
    first_rob = 5'd9; first_src = 1'b1; second_rob = 5'd8; second_src = 1'b0;
`endif
    chk("pause_pre_valid", cdb_valid, 1);
    chk("pause_pre_rob", cdb_rob_id, first_rob);
    rdy_in = 1'b0;
    clear_in = 1'b1;
    offer_alu(10, 'hA0);
    offer_lsb(11, 'hB0);
    #1;
    chk("pause_alu_ready", alu_ready, 0);
    chk("pause_lsb_ready", lsb_ready, 0);
    repeat (3) begin
      tick();
      chk("pause_frozen_valid", cdb_valid, 1);
      chk("pause_frozen_rob", cdb_rob_id, first_rob);
      chk("pause_frozen_src", cdb_src, first_src);
    end
    idle_inputs();
    tick();
    chk("resume_valid", cdb_valid, 1);
    chk("resume_rob", cdb_rob_id, second_rob);
    chk("resume_src", cdb_src, second_src);
    tick();
    chk("resume_done", cdb_valid, 0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
